// File: rtl/mastermind_solver.sv
// mastermind_solver: automatic Mastermind codebreaker (first-consistent search).
// Define MASTERMIND_SOLVER_SEED_EN to add a seed port for the search origin.
module mastermind_solver #(
    parameter int MAX_GUESSES = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
`ifdef MASTERMIND_SOLVER_SEED_EN
    input  logic [11:0] seed,
`endif
    output logic [11:0] guess,
    output logic        guess_valid,
    input  logic        fb_valid,
    input  logic [2:0]  red_in,
    input  logic [2:0]  white_in,
    output logic        busy,
    output logic        solved,
    output logic        failed,
    output logic [3:0]  guess_count
);

    localparam int HW = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;
    localparam int HD = 1 << HW;
    localparam logic [3:0] MAXG = 4'(MAX_GUESSES);

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        ISSUE,
        WON,
        LOST
    } state_t;

    state_t      state;
    logic [11:0] cand;
    logic [11:0] first_cand;
    logic [3:0]  hidx;
    logic [3:0]  count;
    logic [11:0] hg [HD];
    logic [2:0]  hr [HD];
    logic [2:0]  hw [HD];

    function automatic logic [5:0] score(
        input logic [11:0] a,
        input logic [11:0] b
    );
        logic [2:0] red;
        logic [2:0] both;
        logic [2:0] ca;
        logic [2:0] cb;
        red  = '0;
        both = '0;
        for (int i = 0; i < 4; i++) begin
            if (a[3*i +: 3] == b[3*i +: 3]) red = red + 3'd1;
        end
        for (int c = 0; c < 8; c++) begin
            ca = '0;
            cb = '0;
            for (int i = 0; i < 4; i++) begin
                if (a[3*i +: 3] == 3'(c)) ca = ca + 3'd1;
                if (b[3*i +: 3] == 3'(c)) cb = cb + 3'd1;
            end
            both = both + ((ca < cb) ? ca : cb);
        end
        return {red, both - red};
    endfunction

    logic [11:0]   start_cand;
    logic [HW-1:0] hsel;
    logic [HW-1:0] csel;
    logic [5:0]    sc;
    logic          match;
    logic [11:0]   cand_nxt;
    logic [3:0]    count_nxt;

`ifdef MASTERMIND_SOLVER_SEED_EN
    assign start_cand = seed;
`else
    assign start_cand = 12'h000;
`endif

    assign hsel      = hidx[HW-1:0];
    assign csel      = count[HW-1:0];
    assign sc        = score(cand, hg[hsel]);
    assign match     = (sc == {hr[hsel], hw[hsel]});
    assign cand_nxt  = cand + 12'd1;
    assign count_nxt = count + 4'd1;
    assign guess_count = count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cand        <= '0;
            first_cand  <= '0;
            hidx        <= '0;
            count       <= '0;
            guess       <= '0;
            guess_valid <= 1'b0;
            busy        <= 1'b0;
            solved      <= 1'b0;
            failed      <= 1'b0;
            for (int i = 0; i < HD; i++) begin
                hg[i] <= '0;
                hr[i] <= '0;
                hw[i] <= '0;
            end
        end else if (start) begin
            state       <= SEARCH;
            cand        <= start_cand;
            first_cand  <= start_cand;
            hidx        <= '0;
            count       <= '0;
            guess_valid <= 1'b0;
            busy        <= 1'b1;
            solved      <= 1'b0;
            failed      <= 1'b0;
        end else begin
            unique case (state)
                SEARCH: begin
                    if (hidx == count) begin
                        state       <= ISSUE;
                        guess       <= cand;
                        guess_valid <= 1'b1;
                    end else if (match) begin
                        hidx <= hidx + 4'd1;
                    end else if (cand_nxt == first_cand) begin
                        // back at the origin: every code was rejected
                        state  <= LOST;
                        failed <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        cand <= cand_nxt;
                        hidx <= '0;
                    end
                end
                ISSUE: begin
                    if (fb_valid) begin
                        guess_valid <= 1'b0;
                        count       <= count_nxt;
                        if (red_in == 3'd4) begin
                            state  <= WON;
                            solved <= 1'b1;
                            busy   <= 1'b0;
                        end else begin
                            hg[csel] <= cand;
                            hr[csel] <= red_in;
                            hw[csel] <= white_in;
                            if (count_nxt == MAXG) begin
                                state  <= LOST;
                                failed <= 1'b1;
                                busy   <= 1'b0;
                            end else begin
                                // the scored guess cannot match its own feedback
                                state <= SEARCH;
                                cand  <= cand_nxt;
                                hidx  <= '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
